// File: rtl/neuron_mac_sequencer.sv
// ReLU(sum w*x + b) over N_INPUTS pairs through one shared multiplier; f valid 2 edges after last accept.
// Input taken only in RUN (in_ready Moore); result held with out_valid until out_ready.
module neuron_mac_sequencer #(
  parameter int N_INPUTS = 4,
  parameter int W        = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] b,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_x,
  input  logic [W-1:0] in_w,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] f,
  output logic         busy
);

  localparam int CW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_INPUTS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_FINISH,
    S_OUT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  bias_q, bias_d;
  logic [W-1:0]  prod_q, prod_d;
  logic          prod_vld_q, prod_vld_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  f_q, f_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  sum;
  logic          hs;

  assign in_ready  = (state_q == S_RUN);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign f         = f_q;
  assign hs        = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bias_d      = bias_q;
    prod_d      = prod_q;
    prod_vld_d  = 1'b0;
    acc_d       = prod_vld_q ? (acc_q + prod_q) : acc_q;
    f_d         = f_q;
    out_valid_d = out_valid_q;
    sum         = acc_q + bias_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          bias_d  = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (hs) begin
          // Low W bits of the product are the same for signed and unsigned operands.
          prod_d     = in_x * in_w;
          prod_vld_d = 1'b1;
          cnt_d      = cnt_q + CW'(1);
          if (cnt_q == LAST) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        state_d = S_FINISH;
      end
      S_FINISH: begin
        f_d         = sum[W-1] ? '0 : sum;
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bias_q      <= '0;
      prod_q      <= '0;
      prod_vld_q  <= 1'b0;
      acc_q       <= '0;
      f_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bias_q      <= bias_d;
      prod_q      <= prod_d;
      prod_vld_q  <= prod_vld_d;
      acc_q       <= acc_d;
      f_q         <= f_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
